// File: rtl/fpu_pkg.sv
// Shared widths, function-code type and issue-FSM state encoding for the FPU issue path.
package fpu_pkg;

  localparam int FPU_FUNCT_W = 5;
  localparam int FPU_RD_W    = 5;

  typedef logic [FPU_FUNCT_W-1:0] fpu_funct_t;

  localparam fpu_funct_t FUNCT_ADD = 5'd0;
  localparam fpu_funct_t FUNCT_SUB = 5'd1;
  localparam fpu_funct_t FUNCT_MUL = 5'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } fpu_issue_state_t;

endpackage

// File: rtl/fpu_issue_perf.sv
// Issue and stall-cycle counters for the FPU issue unit; only built with FPU_ISSUE_PERF_EN.
module fpu_issue_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue,
  input  logic        stall_cyc,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_stall_cyc
);

  // Both counters wrap naturally and survive flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_ops       <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (issue)     perf_ops       <= perf_ops + 32'd1;
      if (stall_cyc) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end

endmodule

// File: rtl/fpu_issue_unit.sv
// Single-outstanding FP op issue/track/writeback stage between decode and the FPU.
// Optional perf counters enabled by defining FPU_ISSUE_PERF_EN.
//
// state | meaning
// IDLE  | ready for a new op; issues combinationally on req_valid
// WAIT  | op at FPU, waiting for fpu_stall low
// DONE  | result held for writeback; may issue next op on retire
// DRAIN | flushed op still at FPU, result will be discarded
module fpu_issue_unit
  import fpu_pkg::*;
#(
  parameter int FUNCT_W = FPU_FUNCT_W,
  parameter int RD_W    = FPU_RD_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [RD_W-1:0]    req_rd,
  input  logic [31:0]        req_val1,
  input  logic [31:0]        req_val2,
  output logic               fpu_en,
  output logic [FUNCT_W-1:0] fpu_funct,
  output logic [31:0]        fpu_val1,
  output logic [31:0]        fpu_val2,
  input  logic [31:0]        fpu_result,
  input  logic               fpu_stall,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RD_W-1:0]    wb_rd,
  output logic [31:0]        wb_data,
  output logic               busy,
  output logic [RD_W-1:0]    busy_rd
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall_cyc
`endif
);

  fpu_issue_state_t state, next_state;
  logic [RD_W-1:0]  rd_q;
  logic [RD_W-1:0]  wb_rd_q;
  logic [31:0]      wb_data_q;
  logic             issue;
  logic             capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    capture    = 1'b0;
    req_ready  = 1'b0;
    wb_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (!flush && req_valid) begin
          issue      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          next_state = fpu_stall ? DRAIN : IDLE;
        end else if (!fpu_stall) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        wb_valid  = 1'b1;
        req_ready = wb_ready;
        if (flush) begin
          next_state = IDLE;
        end else if (wb_ready) begin
          if (req_valid) begin
            issue      = 1'b1;
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!fpu_stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Keep the issue pulse quiet while reset is held, even if decode is offering.
  assign fpu_en    = issue & ~reset;
  assign fpu_funct = req_funct;
  assign fpu_val1  = req_val1;
  assign fpu_val2  = req_val2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      if (issue) rd_q <= req_rd;
      if (capture) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= fpu_result;
      end
    end
  end

  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign busy    = (state == WAIT) || (state == DONE);
  assign busy_rd = busy ? rd_q : '0;

`ifdef FPU_ISSUE_PERF_EN
  fpu_issue_perf u_perf (
    .clock          (clock),
    .reset          (reset),
    .issue          (fpu_en),
    .stall_cyc      ((state == WAIT) || (state == DRAIN)),
    .perf_ops       (perf_ops),
    .perf_stall_cyc (perf_stall_cyc)
  );
`endif

endmodule
